// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the cpu_ctrl multi-cycle instruction controller:
// opcodes, ALU control codes, branch conditions, PSR bit positions, FSM states.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_BRANCH
    } state_e;

    typedef enum logic [3:0] {
        OP_RTYPE = 4'b0000, OP_ANDI  = 4'b0001, OP_ORI   = 4'b0010,
        OP_XORI  = 4'b0011, OP_ADDI  = 4'b0101, OP_ADDUI = 4'b0110,
        OP_SHIFT = 4'b1000, OP_SUBI  = 4'b1001, OP_CMPI  = 4'b1011,
        OP_BCOND = 4'b1100, OP_MOVI  = 4'b1101, OP_LUI   = 4'b1111
    } opcode_e;

    localparam logic [3:0] EXT_CMP = 4'b1011;
    localparam logic [3:0] EXT_LSH = 4'b0100;

    typedef enum logic [5:0] {
        ALU_NOP  = 6'b000000, ALU_AND  = 6'b000001, ALU_OR   = 6'b000010,
        ALU_XOR  = 6'b000011, ALU_ADD  = 6'b000101, ALU_ADDU = 6'b000110,
        ALU_SUB  = 6'b001001, ALU_CMP  = 6'b001011, ALU_MOV  = 6'b001101,
        ALU_LSH  = 6'b100101, ALU_ASH  = 6'b111100, ALU_LUI  = 6'b111111
    } alu_cont_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_LO = 4'h4, CC_HS = 4'h5, CC_MI = 4'h6, CC_PL = 4'h7,
        CC_FS = 4'h8, CC_FC = 4'h9, CC_HI = 4'hA, CC_LS = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_UC = 4'hE, CC_NV = 4'hF
    } cond_e;

    localparam int PSR_C = 0;
    localparam int PSR_L = 2;
    localparam int PSR_F = 5;
    localparam int PSR_Z = 6;
    localparam int PSR_N = 7;

endpackage

// File: rtl/cpu_ctrl_if.sv
// Fetch/decode/register-file control bundle between cpu_ctrl (master) and
// the datapath plus fetch source (slave).
interface cpu_ctrl_if #(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6
);
    logic [WIDTH-1:0]         instr_data;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [WIDTH-1:0]         psr_flags;
    logic [ALU_CONT_BITS-1:0] alu_cont;
    logic [3:0]               rf_raddr_a;
    logic [3:0]               rf_raddr_b;
    logic [WIDTH-1:0]         imm_out;
    logic                     b_sel_imm;
    logic                     rf_we;
    logic [3:0]               rf_waddr;
    logic [WIDTH-1:0]         pc_out;
    logic                     illegal;

    modport master (
        input  instr_data, instr_valid, psr_flags,
        output instr_ready, alu_cont, rf_raddr_a, rf_raddr_b, imm_out,
               b_sel_imm, rf_we, rf_waddr, pc_out, illegal
    );

    modport slave (
        output instr_data, instr_valid, psr_flags,
        input  instr_ready, alu_cont, rf_raddr_a, rf_raddr_b, imm_out,
               b_sel_imm, rf_we, rf_waddr, pc_out, illegal
    );
endinterface

// File: rtl/cpu_ctrl_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code and the PSR flags
// to a taken bit. Purely combinational.
module cond_eval
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] psr_flags,
    output logic             taken
);
    logic c, l, f, z, n;
    logic unused_psr;

    assign c = psr_flags[PSR_C];
    assign l = psr_flags[PSR_L];
    assign f = psr_flags[PSR_F];
    assign z = psr_flags[PSR_Z];
    assign n = psr_flags[PSR_N];
    assign unused_psr = ^psr_flags;

    always_comb begin
        taken = 1'b0;
        case (cond_e'(cond))
            CC_EQ: taken = z;
            CC_NE: taken = !z;
            CC_CS: taken = c;
            CC_CC: taken = !c;
            CC_LO: taken = l;
            CC_HS: taken = !l;
            CC_MI: taken = n;
            CC_PL: taken = !n;
            CC_FS: taken = f;
            CC_FC: taken = !f;
            CC_HI: taken = !l && !z;
            CC_LS: taken = l || z;
            CC_GT: taken = !n && !z;
            CC_LE: taken = n || z;
            CC_UC: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle instruction controller: FETCH/DECODE/EXEC/WB for ALU ops,
// FETCH/DECODE/BRANCH for conditional branches; owns the PC and the IR.
module cpu_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int ALU_CONT_BITS = 6
) (
    input logic        clk,
    input logic        reset,
    cpu_ctrl_if.master bus
);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(1);

    state_e state_q, state_d;

    logic [WIDTH-1:0]         ir_q, pc_q, imm_q;
    logic [ALU_CONT_BITS-1:0] alu_q;
    logic [3:0]               ra_q, rb_q;
    logic                     bsel_q, wb_en_q;

    logic [3:0]       op, rd, ext, rs;
    logic [WIDTH-1:0] imm_s, imm_z, shamt, dec_imm;
    logic [5:0]       dec_alu;
    logic             dec_bsel, dec_wb, dec_legal, dec_branch, taken;

    assign op    = ir_q[15:12];
    assign rd    = ir_q[11:8];
    assign ext   = ir_q[7:4];
    assign rs    = ir_q[3:0];
    assign imm_s = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};
    assign imm_z = {{(WIDTH-8){1'b0}}, ir_q[7:0]};
    assign shamt = {{(WIDTH-4){1'b0}}, rs};

    // rd doubles as the condition field for branches
    cond_eval #(.WIDTH(WIDTH)) u_cond (
        .cond      (rd),
        .psr_flags (bus.psr_flags),
        .taken     (taken)
    );

    always_comb begin
        dec_alu    = ALU_NOP;
        dec_imm    = '0;
        dec_bsel   = 1'b0;
        dec_wb     = 1'b1;
        dec_legal  = 1'b1;
        dec_branch = 1'b0;
        case (opcode_e'(op))
            OP_RTYPE: begin
                dec_alu = {2'b00, ext};
                dec_wb  = (ext != EXT_CMP);
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: begin
                dec_alu  = {2'b00, op};
                dec_imm  = imm_z;
                dec_bsel = 1'b1;
            end
            OP_ADDI, OP_ADDUI, OP_SUBI, OP_CMPI: begin
                dec_alu  = {2'b00, op};
                dec_imm  = imm_s;
                dec_bsel = 1'b1;
                dec_wb   = (op != OP_CMPI);
            end
            OP_SHIFT: begin
                if (ext == EXT_LSH) begin
                    dec_alu = ALU_LSH;
                end else if (ext[3:1] == 3'b000) begin
                    dec_alu  = ALU_LSH;
                    dec_bsel = 1'b1;
                    dec_imm  = ext[0] ? -shamt : shamt;
                end else begin
                    dec_legal = 1'b0;
                end
            end
            OP_LUI: begin
                dec_alu  = ALU_LUI;
                dec_imm  = imm_z;
                dec_bsel = 1'b1;
            end
            OP_BCOND: begin
                dec_branch = 1'b1;
                dec_wb     = 1'b0;
                dec_imm    = imm_s;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.instr_ready = 1'b0;
        bus.rf_we       = 1'b0;
        bus.rf_waddr    = '0;
        bus.illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.instr_ready = 1'b1;
                if (bus.instr_valid) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.illegal = !dec_legal;
                if (!dec_legal)     state_d = S_FETCH;
                else if (dec_branch) state_d = S_BRANCH;
                else                 state_d = S_EXEC;
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                bus.rf_we    = wb_en_q;
                bus.rf_waddr = rd;
                state_d      = S_FETCH;
            end
            S_BRANCH: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q    <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            bsel_q  <= 1'b0;
            wb_en_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: if (bus.instr_valid) ir_q <= bus.instr_data;
                S_DECODE: begin
                    alu_q   <= ALU_CONT_BITS'(dec_alu);
                    imm_q   <= dec_imm;
                    bsel_q  <= dec_bsel;
                    ra_q    <= rd;
                    rb_q    <= rs;
                    wb_en_q <= dec_wb;
                    if (!dec_legal) pc_q <= pc_q + PC_STEP;
                end
                S_WB:     pc_q <= pc_q + PC_STEP;
                S_BRANCH: pc_q <= taken ? pc_q + imm_s : pc_q + PC_STEP;
                default: ;
            endcase
        end
    end

    assign bus.alu_cont   = alu_q;
    assign bus.imm_out    = imm_q;
    assign bus.b_sel_imm  = bsel_q;
    assign bus.rf_raddr_a = ra_q;
    assign bus.rf_raddr_b = rb_q;
    assign bus.pc_out     = pc_q;
endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: each issued instruction queues its expected
// end-of-instruction state; a negedge monitor checks it when FETCH returns.
module tb_cpu_ctrl;
    logic clk = 1'b0;
    logic reset;

    cpu_ctrl_if #(.WIDTH(16), .ALU_CONT_BITS(6)) bus ();

    cpu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic [5:0]  alu;
        logic [15:0] imm;
        logic        bsel;
        logic        we;
        logic [3:0]  wa, ra, rb;
        logic        ill;
        logic        c_alu, c_imm, c_ra;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   we_total = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic exp_t ex_alu(input logic [15:0] w, input logic [15:0] pc,
                                    input logic [5:0] alu, input logic [15:0] imm,
                                    input logic bsel, input logic we, input logic c_imm);
        exp_t e;
        e.pc = pc; e.alu = alu; e.imm = imm; e.bsel = bsel; e.we = we;
        e.wa = w[11:8]; e.ra = w[11:8]; e.rb = w[3:0]; e.ill = 1'b0;
        e.c_alu = 1'b1; e.c_imm = c_imm; e.c_ra = 1'b1;
        return e;
    endfunction

    function automatic exp_t ex_br(input logic [15:0] pc);
        exp_t e;
        e = ex_alu(16'h0, pc, 6'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        e.c_alu = 1'b0; e.c_ra = 1'b0;
        return e;
    endfunction

    function automatic exp_t ex_ill(input logic [15:0] pc);
        exp_t e;
        e = ex_alu(16'h0, pc, 6'h0, 16'h0, 1'b0, 1'b0, 1'b0);
        e.ill = 1'b1; e.c_ra = 1'b0;
        return e;
    endfunction

    // Monitor: tracks one in-flight instruction from handshake to return to FETCH
    logic busy = 1'b0;
    int   cyc, we_cnt, we_cyc, ill_cnt;
    logic [3:0] got_wa;

    always @(negedge clk) begin
        if (bus.rf_we) we_total++;
        if (reset) begin
            busy = 1'b0;
        end else begin
            if (busy) begin
                cyc++;
                if (bus.rf_we) begin we_cnt++; we_cyc = cyc; got_wa = bus.rf_waddr; end
                if (bus.illegal) ill_cnt++;
                if (bus.instr_ready) begin
                    busy = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("pc_out", bus.pc_out, e.pc);
                        check("rf_we_pulses", we_cnt, e.we);
                        check("illegal_pulses", ill_cnt, e.ill);
                        if (e.we) begin
                            check("rf_waddr", got_wa, e.wa);
                            check("rf_we_cycle", we_cyc, 3);
                        end
                        if (e.c_alu) begin
                            check("alu_cont", bus.alu_cont, e.alu);
                            check("b_sel_imm", bus.b_sel_imm, e.bsel);
                        end
                        if (e.c_imm) check("imm_out", bus.imm_out, e.imm);
                        if (e.c_ra) begin
                            check("rf_raddr_a", bus.rf_raddr_a, e.ra);
                            check("rf_raddr_b", bus.rf_raddr_b, e.rb);
                        end
                    end
                end
            end
            if (bus.instr_ready && bus.instr_valid) begin
                busy = 1'b1; cyc = 0; we_cnt = 0; we_cyc = 0; ill_cnt = 0; got_wa = '0;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 once FETCH is re-entered
    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.instr_ready && n < 20) begin @(posedge clk); #1; n++; end
        if (!bus.instr_ready) check(nm, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [15:0] w, input exp_t e);
        wait_ready("timeout_ready_before");
        exp_q.push_back(e);
        bus.instr_data  = w;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        wait_ready("timeout_ready_after");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.instr_data  = '0;
        bus.instr_valid = 1'b0;
        bus.psr_flags   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", bus.pc_out, 16'h0);
        check("rst_alu", bus.alu_cont, 6'h0);
        check("rst_imm", bus.imm_out, 16'h0);
        check("rst_bsel", bus.b_sel_imm, 1'b0);
        check("rst_we", bus.rf_we, 1'b0);
        check("rst_waddr", bus.rf_waddr, 4'h0);
        check("rst_ra", {bus.rf_raddr_a, bus.rf_raddr_b}, 8'h00);
        check("rst_illegal", bus.illegal, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", bus.instr_ready, 1'b1);

        send(16'h53FF, ex_alu(16'h53FF, 16'h0001, 6'b000101, 16'hFFFF, 1'b1, 1'b1, 1'b1));

        // idle: no handshake, nothing moves
        for (int i = 0; i < 10; i++) begin
            check("idle_ready", bus.instr_ready, 1'b1);
            check("idle_pc", bus.pc_out, 16'h0001);
            check("idle_alu", bus.alu_cont, 6'b000101);
            check("idle_we", bus.rf_we, 1'b0);
            @(posedge clk); #1;
        end

        send(16'h1180, ex_alu(16'h1180, 16'h0002, 6'b000001, 16'h0080, 1'b1, 1'b1, 1'b1));
        send(16'h8213, ex_alu(16'h8213, 16'h0003, 6'b100101, 16'hFFFD, 1'b1, 1'b1, 1'b1));
        send(16'h01B2, ex_alu(16'h01B2, 16'h0004, 6'b001011, 16'h0000, 1'b0, 1'b0, 1'b0));
        send(16'h4123, ex_ill(16'h0005));
        bus.psr_flags = 16'h0040;
        send(16'hC0FE, ex_br(16'h0003));
        send(16'hF4AB, ex_alu(16'hF4AB, 16'h0004, 6'b111111, 16'h00AB, 1'b1, 1'b1, 1'b1));
        send(16'h9580, ex_alu(16'h9580, 16'h0005, 6'b001001, 16'hFF80, 1'b1, 1'b1, 1'b1));
        bus.psr_flags = 16'h0000;
        send(16'hC0FE, ex_br(16'h0006));
        send(16'hD7FF, ex_alu(16'hD7FF, 16'h0007, 6'b001101, 16'h00FF, 1'b1, 1'b1, 1'b1));
        send(16'hCEF8, ex_br(16'hFFFF));
        send(16'hCE01, ex_br(16'h0000));
        send(16'hCF10, ex_br(16'h0001));
        bus.psr_flags = 16'h0001;
        send(16'hC204, ex_br(16'h0005));
        send(16'hC304, ex_br(16'h0006));
        send(16'h8143, ex_alu(16'h8143, 16'h0007, 6'b100101, 16'h0000, 1'b0, 1'b1, 1'b0));
        send(16'h6A7F, ex_alu(16'h6A7F, 16'h0008, 6'b000110, 16'h007F, 1'b1, 1'b1, 1'b1));
        bus.psr_flags = 16'h0004;
        send(16'hCB02, ex_br(16'h000A));

        // abort an ADDI in EXEC with reset
        begin
            int we_before;
            we_before = we_total;
            bus.instr_data  = 16'h5601;
            bus.instr_valid = 1'b1;
            @(posedge clk); #1;
            bus.instr_valid = 1'b0;
            @(posedge clk); #1;
            check("abort_in_exec", bus.alu_cont, 6'b000101);
            #2 reset = 1'b1;
            #1;
            check("abort_pc", bus.pc_out, 16'h0000);
            check("abort_alu", bus.alu_cont, 6'h0);
            check("abort_imm", bus.imm_out, 16'h0);
            check("abort_we", bus.rf_we, 1'b0);
            @(posedge clk); #1;
            reset = 1'b0;
            @(posedge clk); #1;
            check("abort_ready", bus.instr_ready, 1'b1);
            check("abort_pc_after", bus.pc_out, 16'h0000);
            check("abort_no_we", we_total, we_before);
        end

        send(16'h53FF, ex_alu(16'h53FF, 16'h0001, 6'b000101, 16'hFFFF, 1'b1, 1'b1, 1'b1));

        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
